udp_tx_arbiter: RTL and testbench

Shares the single UDP transmit port of `udp_mac_complete` (header + AXI-stream payload) between `NUM_REQ` independent packet sources, such as the controller's command-reply path and a bulk acquisition streamer. It arbitrates round-robin at packet granularity. Once a requester's header is granted, the arbiter locks onto it until the payload `tlast` beat is transferred, so packets never interleave. It sits between the requesters and the `tx_udp_*` inputs of `udp_mac_complete`, in the `clk` domain.

---
 rtl/udp_tx_arbiter_pkg.sv | 24 ++
 rtl/udp_tx_arbiter_rr_pick.sv | 28 ++
 rtl/udp_tx_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_udp_tx_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_tx_arbiter_pkg.sv
// Shared types and widths for the UDP transmit arbiter and its round-robin picker.
package udp_tx_arbiter_pkg;
   localparam int IP_W            = 32;
   localparam int PORT_W          = 16;
   localparam int DATA_W          = 8;
   localparam int UDP_ARB_MAX_REQ = 8;
   localparam int GRANT_W         = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HDR     = 2'd1,
      PAYLOAD = 2'd2
`ifdef UDP_TX_ARB_TIMEOUT_EN
      , ABORT = 2'd3
`endif
   } udp_arb_state_t;

   typedef struct packed {
      logic [IP_W-1:0]   ip_dest_ip;
      logic [PORT_W-1:0] udp_source_port;
      logic [PORT_W-1:0] udp_dest_port;
      logic [PORT_W-1:0] udp_length;
   } hdr_t;
endpackage

// File: rtl/udp_tx_arbiter_rr_pick.sv
// Combinational round-robin finder: first set request bit searching upward from last_ptr+1, wrapping.
// Zero latency; no state, so no backpressure of its own.
module udp_tx_arbiter_rr_pick
   import udp_tx_arbiter_pkg::*;
#(
   parameter int N = 2
) (
   input  logic [N-1:0]       req,
   input  logic [GRANT_W-1:0] last_ptr,
   output logic [GRANT_W-1:0] idx,
   output logic               any
);

   // Candidate order is last+1, last+2, ... so the first hit wins; indices stay constant after unrolling.
   always_comb begin
      idx = last_ptr;
      any = 1'b0;
      for (int k = 1; k <= N; k++) begin
         for (int j = 0; j < N; j++) begin
            if (!any && req[j] && ((int'(last_ptr) + k) % N == j)) begin
               any = 1'b1;
               idx = GRANT_W'(j);
            end
         end
      end
   end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Packet-granular round-robin arbiter onto one UDP tx port: header 1 cycle after request, payload pass-through with no added latency.
// Ready from the MAC is steered only to the granted source; optional stall watchdog under UDP_TX_ARB_TIMEOUT_EN.
module udp_tx_arbiter
   import udp_tx_arbiter_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_hdr_valid,
   output logic [NUM_REQ-1:0]        req_hdr_ready,
   input  logic [IP_W*NUM_REQ-1:0]   req_ip_dest_ip,
   input  logic [PORT_W*NUM_REQ-1:0] req_udp_source_port,
   input  logic [PORT_W*NUM_REQ-1:0] req_udp_dest_port,
   input  logic [PORT_W*NUM_REQ-1:0] req_udp_length,
   input  logic [DATA_W*NUM_REQ-1:0] req_payload_tdata,
   input  logic [NUM_REQ-1:0]        req_payload_tvalid,
   input  logic [NUM_REQ-1:0]        req_payload_tlast,
   input  logic [NUM_REQ-1:0]        req_payload_tuser,
   output logic [NUM_REQ-1:0]        req_payload_tready,
   output logic                      out_udp_hdr_valid,
   input  logic                      out_udp_hdr_ready,
   output logic [IP_W-1:0]           out_ip_dest_ip,
   output logic [PORT_W-1:0]         out_udp_source_port,
   output logic [PORT_W-1:0]         out_udp_dest_port,
   output logic [PORT_W-1:0]         out_udp_length,
   output logic [DATA_W-1:0]         out_payload_tdata,
   output logic                      out_payload_tvalid,
   output logic                      out_payload_tlast,
   output logic                      out_payload_tuser,
   input  logic                      out_payload_tready,
   output logic [GRANT_W-1:0]        grant_id,
   output logic                      busy,
   output logic [15:0]               abort_count
);

   localparam logic [GRANT_W-1:0] LAST_RST = GRANT_W'(NUM_REQ - 1);

   udp_arb_state_t     state_q, state_d;
   logic [GRANT_W-1:0] grant_q, grant_d;
   logic [GRANT_W-1:0] last_q, last_d;
   logic [GRANT_W-1:0] pick_idx;
   logic               pick_any;

   hdr_t               sel_hdr;
   logic               sel_hdr_vld;
   logic [DATA_W-1:0]  sel_tdata;
   logic               sel_tvalid, sel_tlast, sel_tuser;
   logic               hdr_hs, beat_hs;

   udp_tx_arbiter_rr_pick #(.N(NUM_REQ)) u_rr_pick (
      .req      (req_hdr_valid),
      .last_ptr (last_q),
      .idx      (pick_idx),
      .any      (pick_any)
   );

   always_comb begin
      sel_hdr     = '0;
      sel_hdr_vld = 1'b0;
      sel_tdata   = '0;
      sel_tvalid  = 1'b0;
      sel_tlast   = 1'b0;
      sel_tuser   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q == GRANT_W'(i)) begin
            sel_hdr_vld             = req_hdr_valid[i];
            sel_hdr.ip_dest_ip      = req_ip_dest_ip[IP_W*i +: IP_W];
            sel_hdr.udp_source_port = req_udp_source_port[PORT_W*i +: PORT_W];
            sel_hdr.udp_dest_port   = req_udp_dest_port[PORT_W*i +: PORT_W];
            sel_hdr.udp_length      = req_udp_length[PORT_W*i +: PORT_W];
            sel_tdata               = req_payload_tdata[DATA_W*i +: DATA_W];
            sel_tvalid              = req_payload_tvalid[i];
            sel_tlast               = req_payload_tlast[i];
            sel_tuser               = req_payload_tuser[i];
         end
      end
   end

   assign hdr_hs  = (state_q == HDR) && sel_hdr_vld && out_udp_hdr_ready;
   assign beat_hs = (state_q == PAYLOAD) && sel_tvalid && out_payload_tready;

   // Outputs decode from registered state only, so an async reset zeroes them immediately.
   always_comb begin
      out_udp_hdr_valid   = 1'b0;
      out_ip_dest_ip      = '0;
      out_udp_source_port = '0;
      out_udp_dest_port   = '0;
      out_udp_length      = '0;
      out_payload_tdata   = '0;
      out_payload_tvalid  = 1'b0;
      out_payload_tlast   = 1'b0;
      out_payload_tuser   = 1'b0;
      req_hdr_ready       = '0;
      req_payload_tready  = '0;
      case (state_q)
         HDR: begin
            out_udp_hdr_valid   = sel_hdr_vld;
            out_ip_dest_ip      = sel_hdr.ip_dest_ip;
            out_udp_source_port = sel_hdr.udp_source_port;
            out_udp_dest_port   = sel_hdr.udp_dest_port;
            out_udp_length      = sel_hdr.udp_length;
            for (int i = 0; i < NUM_REQ; i++)
               req_hdr_ready[i] = (grant_q == GRANT_W'(i)) && out_udp_hdr_ready;
         end
         PAYLOAD: begin
            out_payload_tdata  = sel_tdata;
            out_payload_tvalid = sel_tvalid;
            out_payload_tlast  = sel_tlast;
            out_payload_tuser  = sel_tuser;
            for (int i = 0; i < NUM_REQ; i++)
               req_payload_tready[i] = (grant_q == GRANT_W'(i)) && out_payload_tready;
         end
`ifdef UDP_TX_ARB_TIMEOUT_EN
         ABORT: begin
            out_payload_tvalid = 1'b1;
            out_payload_tlast  = 1'b1;
            out_payload_tuser  = 1'b1;
         end
`endif
         default: ;
      endcase
   end

`ifdef UDP_TX_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] stall_q, stall_d;
   logic [15:0]      abort_cnt_q, abort_cnt_d;
   logic             stall_expire;

   // Only cycles with no valid from the source count; a valid beat held off by the MAC does not.
   assign stall_expire = (state_q == PAYLOAD) && !sel_tvalid &&
                         (stall_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      stall_d     = '0;
      abort_cnt_d = abort_cnt_q;
      if (state_q == PAYLOAD && !beat_hs)
         stall_d = sel_tvalid ? stall_q : stall_q + 1'b1;
      if (state_q == ABORT && out_payload_tready && abort_cnt_q != 16'hFFFF)
         abort_cnt_d = abort_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q     <= '0;
         abort_cnt_q <= '0;
      end else begin
         stall_q     <= stall_d;
         abort_cnt_q <= abort_cnt_d;
      end
   end

   assign abort_count = abort_cnt_q;
`else
   logic unused_timeout;
   assign unused_timeout = ^32'(TIMEOUT_CYCLES);
   assign abort_count    = '0;
`endif

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               grant_d = pick_idx;
               state_d = HDR;
            end
         end
         HDR: begin
            if (hdr_hs)
               state_d = PAYLOAD;
         end
         PAYLOAD: begin
            if (beat_hs && sel_tlast) begin
               last_d  = grant_q;
               state_d = IDLE;
            end
`ifdef UDP_TX_ARB_TIMEOUT_EN
            else if (stall_expire)
               state_d = ABORT;
`endif
         end
`ifdef UDP_TX_ARB_TIMEOUT_EN
         ABORT: begin
            if (out_payload_tready) begin
               last_d  = grant_q;
               state_d = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= LAST_RST;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   assign grant_id = grant_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Scoreboard bench for udp_tx_arbiter: directed packets, expected headers/beats queued in grant order.
module tb_udp_tx_arbiter;
   localparam int N   = 3;
   localparam int TMO = 400;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [N-1:0]    req_hdr_valid, req_hdr_ready;
   logic [32*N-1:0] req_ip_dest_ip;
   logic [16*N-1:0] req_udp_source_port, req_udp_dest_port, req_udp_length;
   logic [8*N-1:0]  req_payload_tdata;
   logic [N-1:0]    req_payload_tvalid, req_payload_tlast, req_payload_tuser, req_payload_tready;
   logic            out_udp_hdr_valid, out_udp_hdr_ready;
   logic [31:0]     out_ip_dest_ip;
   logic [15:0]     out_udp_source_port, out_udp_dest_port, out_udp_length;
   logic [7:0]      out_payload_tdata;
   logic            out_payload_tvalid, out_payload_tlast, out_payload_tuser, out_payload_tready;
   logic [2:0]      grant_id;
   logic            busy;
   logic [15:0]     abort_count;

   logic        hv [N];
   logic [31:0] hip[N];
   logic [15:0] hsp[N], hdp[N], hln[N];
   logic        pv [N], pl[N], pu[N];
   logic [7:0]  pd [N];

   always_comb begin
      for (int i = 0; i < N; i++) begin
         req_hdr_valid[i]              = hv[i];
         req_ip_dest_ip[32*i +: 32]    = hip[i];
         req_udp_source_port[16*i +: 16] = hsp[i];
         req_udp_dest_port[16*i +: 16] = hdp[i];
         req_udp_length[16*i +: 16]    = hln[i];
         req_payload_tdata[8*i +: 8]   = pd[i];
         req_payload_tvalid[i]         = pv[i];
         req_payload_tlast[i]          = pl[i];
         req_payload_tuser[i]          = pu[i];
      end
   end

   udp_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst),
      .req_hdr_valid(req_hdr_valid), .req_hdr_ready(req_hdr_ready),
      .req_ip_dest_ip(req_ip_dest_ip), .req_udp_source_port(req_udp_source_port),
      .req_udp_dest_port(req_udp_dest_port), .req_udp_length(req_udp_length),
      .req_payload_tdata(req_payload_tdata), .req_payload_tvalid(req_payload_tvalid),
      .req_payload_tlast(req_payload_tlast), .req_payload_tuser(req_payload_tuser),
      .req_payload_tready(req_payload_tready),
      .out_udp_hdr_valid(out_udp_hdr_valid), .out_udp_hdr_ready(out_udp_hdr_ready),
      .out_ip_dest_ip(out_ip_dest_ip), .out_udp_source_port(out_udp_source_port),
      .out_udp_dest_port(out_udp_dest_port), .out_udp_length(out_udp_length),
      .out_payload_tdata(out_payload_tdata), .out_payload_tvalid(out_payload_tvalid),
      .out_payload_tlast(out_payload_tlast), .out_payload_tuser(out_payload_tuser),
      .out_payload_tready(out_payload_tready),
      .grant_id(grant_id), .busy(busy), .abort_count(abort_count)
   );

   typedef struct { logic [2:0] gid; logic [31:0] ip; logic [15:0] sp, dp, ln; } hexp_t;
   typedef struct { logic [2:0] gid; logic [7:0] d; logic l, u; } bexp_t;
   hexp_t hdr_q[$];
   bexp_t beat_q[$];

   int n_chk = 0, n_fail = 0;
   int cyc = 0, beats_seen = 0, tlast_cyc = -100, last_gap = 0;
   bit chk_excl = 1'b0, bp_done = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compares every output handshake against the head of the matching queue.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_udp_hdr_valid && out_udp_hdr_ready) begin
            last_gap = cyc - tlast_cyc;
            if (hdr_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL hdr_unexpected: got header from grant %0d, expected none", grant_id);
            end else begin
               hexp_t e;
               e = hdr_q.pop_front();
               chk("hdr", 96'({grant_id, out_ip_dest_ip, out_udp_source_port, out_udp_dest_port, out_udp_length}),
                          96'({e.gid, e.ip, e.sp, e.dp, e.ln}));
            end
         end
         if (out_payload_tvalid && out_payload_tready) begin
            beats_seen++;
            if (out_payload_tlast) tlast_cyc = cyc;
            if (beat_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL beat_unexpected: got data %0h grant %0d, expected none", out_payload_tdata, grant_id);
            end else begin
               bexp_t b;
               b = beat_q.pop_front();
               chk("beat", 96'({grant_id, out_payload_tdata, out_payload_tlast, out_payload_tuser}),
                           96'({b.gid, b.d, b.l, b.u}));
            end
         end
         if (chk_excl)
            for (int i = 0; i < N; i++)
               if (i != int'(grant_id)) chk("excl_tready", 96'(req_payload_tready[i]), 96'(0));
      end
   end

   task automatic expect_pkt(input int r, input logic [31:0] ip, input logic [15:0] sp, input logic [15:0] dp,
                             input int len, input logic [7:0] base, input int nb, input bit ulast);
      hexp_t h;
      bexp_t b;
      h.gid = 3'(r); h.ip = ip; h.sp = sp; h.dp = dp; h.ln = 16'(8 + len);
      hdr_q.push_back(h);
      for (int k = 0; k < nb; k++) begin
         b.gid = 3'(r); b.d = base + 8'(k); b.l = (k == len - 1); b.u = ulast && (k == len - 1);
         beat_q.push_back(b);
      end
   endtask

   // Drives one requester; sends nb of len bytes and gives up quietly if reset hits mid-packet.
   task automatic send_pkt(input int r, input logic [31:0] ip, input logic [15:0] sp, input logic [15:0] dp,
                           input int len, input logic [7:0] base, input int nb, input bit ulast);
      bit hs;
      int n;
      @(posedge clk); #1;
      hv[r] = 1'b1; hip[r] = ip; hsp[r] = sp; hdp[r] = dp; hln[r] = 16'(8 + len);
      hs = 1'b0; n = 0;
      while (!hs && n < TMO && !rst) begin
         @(negedge clk); hs = req_hdr_ready[r];
         @(posedge clk); #1; n++;
      end
      hv[r] = 1'b0;
      if (!hs) begin
         if (!rst) begin n_chk++; n_fail++; $display("FAIL hdr_timeout: requester %0d got no grant, expected one", r); end
         return;
      end
      for (int k = 0; k < nb; k++) begin
         pv[r] = 1'b1; pd[r] = base + 8'(k); pl[r] = (k == len - 1); pu[r] = ulast && (k == len - 1);
         hs = 1'b0; n = 0;
         while (!hs && n < TMO && !rst) begin
            @(negedge clk); hs = req_payload_tready[r];
            @(posedge clk); #1; n++;
         end
         if (!hs) begin
            if (!rst) begin n_chk++; n_fail++; $display("FAIL beat_timeout: requester %0d byte %0d not taken, expected taken", r, k); end
            break;
         end
      end
      pv[r] = 1'b0; pl[r] = 1'b0; pu[r] = 1'b0; pd[r] = '0;
   endtask

   initial begin
      int n, b0;
      rst = 1'b1;
      out_udp_hdr_ready = 1'b1;
      out_payload_tready = 1'b1;
      for (int i = 0; i < N; i++) begin
         hv[i] = 0; hip[i] = 0; hsp[i] = 0; hdp[i] = 0; hln[i] = 0; pv[i] = 0; pd[i] = 0; pl[i] = 0; pu[i] = 0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_hdr_valid", 96'(out_udp_hdr_valid), 96'(0));
      chk("rst_tvalid", 96'(out_payload_tvalid), 96'(0));
      chk("rst_busy", 96'(busy), 96'(0));
      chk("rst_grant", 96'(grant_id), 96'(0));
      chk("rst_abort_count", 96'(abort_count), 96'(0));
      chk("rst_readys", 96'({req_hdr_ready, req_payload_tready}), 96'(0));
      @(posedge clk); #1 rst = 1'b0;

      // Single packet from requester 1: 192.168.1.10:5000, bytes A0..A3.
      expect_pkt(1, 32'hC0A8010A, 16'd1234, 16'd5000, 4, 8'hA0, 4, 1'b0);
      fork
         send_pkt(1, 32'hC0A8010A, 16'd1234, 16'd5000, 4, 8'hA0, 4, 1'b0);
         begin
            @(posedge clk); #1;
            @(negedge clk); chk("lat_idle_cycle", 96'(out_udp_hdr_valid), 96'(0));
            @(negedge clk); chk("lat_hdr_valid", 96'(out_udp_hdr_valid), 96'(1));
            chk("grant_single", 96'(grant_id), 96'(1));
         end
      join
      repeat (2) @(posedge clk);

      // Late arrival: requester 0 asks while requester 1 is mid-payload.
      expect_pkt(1, 32'h0A000001, 16'd7001, 16'd7002, 6, 8'hC0, 6, 1'b0);
      expect_pkt(0, 32'h0A000002, 16'd7003, 16'd7004, 2, 8'hD0, 2, 1'b0);
      b0 = beats_seen;
      fork
         send_pkt(1, 32'h0A000001, 16'd7001, 16'd7002, 6, 8'hC0, 6, 1'b0);
         begin
            n = 0;
            while (beats_seen < b0 + 2 && n < TMO) begin @(posedge clk); n++; end
            send_pkt(0, 32'h0A000002, 16'd7003, 16'd7004, 2, 8'hD0, 2, 1'b0);
         end
      join
      chk("bubble_gap", 96'(last_gap), 96'(2));
      repeat (2) @(posedge clk);

      // Backpressure: 16 bytes from requester 2 with tready toggling every cycle.
      expect_pkt(2, 32'hC0A80005, 16'd4000, 16'd4001, 16, 8'hB0, 16, 1'b1);
      bp_done = 1'b0;
      fork
         begin send_pkt(2, 32'hC0A80005, 16'd4000, 16'd4001, 16, 8'hB0, 16, 1'b1); bp_done = 1'b1; end
         begin
            chk_excl = 1'b1; n = 0;
            while (!bp_done && n < TMO) begin @(posedge clk); #1 out_payload_tready = ~out_payload_tready; n++; end
            out_payload_tready = 1'b1; chk_excl = 1'b0;
         end
      join
      repeat (2) @(posedge clk);

      // Contention: all three request together twice; pointer sits at 2 so order is 0,1,2,0,1,2.
      for (int p = 0; p < 2; p++)
         for (int r = 0; r < N; r++)
            expect_pkt(r, 32'hAC100000 + 32'(r), 16'(1000 + r), 16'(2000 + p), 3, 8'(8'h40 * p + 8'h10 * r), 3, 1'b0);
      fork
         begin
            send_pkt(0, 32'hAC100000, 16'd1000, 16'd2000, 3, 8'h00, 3, 1'b0);
            send_pkt(0, 32'hAC100000, 16'd1000, 16'd2001, 3, 8'h40, 3, 1'b0);
         end
         begin
            send_pkt(1, 32'hAC100001, 16'd1001, 16'd2000, 3, 8'h10, 3, 1'b0);
            send_pkt(1, 32'hAC100001, 16'd1001, 16'd2001, 3, 8'h50, 3, 1'b0);
         end
         begin
            send_pkt(2, 32'hAC100002, 16'd1002, 16'd2000, 3, 8'h20, 3, 1'b0);
            send_pkt(2, 32'hAC100002, 16'd1002, 16'd2001, 3, 8'h60, 3, 1'b0);
         end
      join
      repeat (2) @(posedge clk);

      // Move the pointer to 0, then reset requester 1 while its second byte is on the bus.
      expect_pkt(0, 32'h01020304, 16'd9, 16'd10, 2, 8'h70, 2, 1'b0);
      send_pkt(0, 32'h01020304, 16'd9, 16'd10, 2, 8'h70, 2, 1'b0);
      repeat (2) @(posedge clk);
      expect_pkt(1, 32'h05060708, 16'd11, 16'd12, 4, 8'h80, 1, 1'b0);
      b0 = beats_seen;
      fork
         send_pkt(1, 32'h05060708, 16'd11, 16'd12, 4, 8'h80, 4, 1'b0);
         begin
            n = 0;
            while (beats_seen < b0 + 1 && n < TMO) begin @(posedge clk); n++; end
            #2 rst = 1'b1;
            #1;
            chk("arst_tvalid", 96'(out_payload_tvalid), 96'(0));
            chk("arst_tdata", 96'(out_payload_tdata), 96'(0));
            chk("arst_busy", 96'(busy), 96'(0));
            chk("arst_grant", 96'(grant_id), 96'(0));
            chk("arst_tready", 96'(req_payload_tready), 96'(0));
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
         end
      join
      repeat (2) @(posedge clk);
      expect_pkt(0, 32'h0B0B0B0B, 16'd21, 16'd22, 2, 8'h90, 2, 1'b0);
      expect_pkt(1, 32'h0C0C0C0C, 16'd23, 16'd24, 2, 8'h98, 2, 1'b0);
      fork
         send_pkt(0, 32'h0B0B0B0B, 16'd21, 16'd22, 2, 8'h90, 2, 1'b0);
         send_pkt(1, 32'h0C0C0C0C, 16'd23, 16'd24, 2, 8'h98, 2, 1'b0);
      join
      repeat (2) @(posedge clk);

`ifdef UDP_TX_ARB_TIMEOUT_EN
      // Requester 2 stalls after 2 of 5 bytes; the watchdog emits an abort beat, then requester 0 goes.
      begin
         bexp_t ab;
         expect_pkt(2, 32'h0D0D0D0D, 16'd31, 16'd32, 5, 8'hE0, 2, 1'b0);
         ab.gid = 3'd2; ab.d = 8'h00; ab.l = 1'b1; ab.u = 1'b1;
         beat_q.push_back(ab);
         expect_pkt(0, 32'h0E0E0E0E, 16'd33, 16'd34, 2, 8'hF0, 2, 1'b0);
         fork
            send_pkt(2, 32'h0D0D0D0D, 16'd31, 16'd32, 5, 8'hE0, 2, 1'b0);
            begin repeat (3) @(posedge clk); send_pkt(0, 32'h0E0E0E0E, 16'd33, 16'd34, 2, 8'hF0, 2, 1'b0); end
         join
         repeat (2) @(posedge clk);
         @(negedge clk);
         chk("abort_count", 96'(abort_count), 96'(1));
      end
`else
      @(negedge clk);
      chk("abort_count_zero", 96'(abort_count), 96'(0));
`endif

      @(negedge clk);
      chk("hdr_q_drained", 96'(hdr_q.size()), 96'(0));
      chk("beat_q_drained", 96'(beat_q.size()), 96'(0));
      chk("idle_at_end", 96'(busy), 96'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
